noc_mcast_fork: RTL and testbench
=================================

NOC_MCAST_FORK -- requirements
Module: noc_mcast_fork

Interface
REQ-001 Parameter NumDest, default 2: destination slots per head flit; legal range 1..8.
REQ-002 Parameter DataWidth, default 64: flit width including the 2-bit preamble; must be at least 2 + 6*(NumDest+1) + 5 + NumDest.
REQ-003 Parameter PortsEn, default 5'b11111: output port enable mask, bit order {local,east,west,south,north}.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 position  input  6  router coordinate {y[2:0],x[2:0]}; quasi-static.
REQ-007 data_in  input  DataWidth  incoming flit.
REQ-008 data_in_valid  input  1  incoming flit valid.
REQ-009 data_in_ready  output  1  incoming flit consumed this cycle.
REQ-010 data_out  output  5xDataWidth  per-port outgoing flit, port order N,S,W,E,L.
REQ-011 data_out_valid  output  5  per-port valid.
REQ-012 data_out_ready  input  5  per-port downstream ready.

Function
REQ-013 Flit layout SHALL be: [DW-1]=head; [DW-2]=tail; header bits from LSB are val[NumDest-1:0], message[4:0], destination[NumDest-1:0] (6 bits each, slot 0 lowest), then source (6 bits). Bits above the header are payload.
REQ-014 For each destination slot i with val[i]=1, the port SHALL be: dest.x>pos.x east; dest.x<pos.x west; else dest.y<pos.y north; dest.y>pos.y south; else local.
REQ-015 route_mask[p] SHALL be the OR over valid slots routed to port p. route_mask bits for ports disabled in PortsEn SHALL be forced to 0.
REQ-016 FSM states: IDLE (waiting for head), FWD (forwarding a packet), DROP (discarding a packet).
REQ-017 IDLE, valid head flit: latch route_mask and per-port val masks. If route_mask==0, go to DROP; otherwise forward the head and go to FWD. A single-flit packet (head and tail both set) returns to IDLE on completion.
REQ-018 IDLE, valid non-head flit: consume and discard it (data_in_ready=1); stay in IDLE.
REQ-019 Head copy to port p SHALL be identical to the input flit except val, which is replaced by the mask of slots routed to p. Body and tail flits SHALL be replicated unchanged.
REQ-020 data_out_valid[p] SHALL equal valid_in & route_mask[p] & ~sent[p]. sent is a 5-bit register of ports that have already accepted the current flit.
REQ-021 A port accepts when its valid and ready are both high; sent[p] is set on acceptance.
REQ-022 data_in_ready SHALL be high in the cycle when every routed port has either accepted earlier or accepts now. In that cycle sent clears to 0 (a combinational ready path is allowed).
REQ-023 Partial acceptance: a port that has accepted SHALL NOT be re-presented the same flit. The flit is held on the other ports until they accept.
REQ-024 A tail flit consumed in FWD or DROP SHALL return the FSM to IDLE. In DROP every flit is consumed at one flit per cycle with all data_out_valid low.
REQ-025 route_mask and the val masks SHALL hold from head to tail. A head flit arriving in FWD/DROP is treated as body.
REQ-026 Latency: zero cycles, combinational flit-to-output. No storage beyond the route and sent registers.

Reset
REQ-027 On rst=1, the block SHALL asynchronously enter IDLE with route_mask=0, sent=0, val masks=0, data_out_valid=0 and data_in_ready=0 (while in reset).
REQ-028 Reset asserted mid-packet SHALL abandon the packet. After release, flits are discarded until the next head.
REQ-029 data_out SHALL be don't-care whenever the matching valid is low.

Verification
REQ-030 pos=(3,3); head with NumDest=2, dst0=(5,3) val0, dst1=(3,1) val1; all ready -> east and north valid same cycle; east val=2'b01, north val=2'b10; data_in_ready=1.
REQ-031 Same packet (head, body, tail); east ready held low 3 cycles -> north accepts the head in cycle 0 and stays low after; east accepts in cycle 3; data_in_ready goes high only in cycle 3; body follows.
REQ-032 pos=(3,3); both slots=(3,3), val=2'b11 -> only local valid, head val=2'b11; single-flit packet (head and tail set) -> FSM back in IDLE the next cycle.
REQ-033 Head with val=2'b00, then 2 bodies and a tail -> 4 flits consumed in 4 cycles; no data_out_valid; IDLE afterwards.
REQ-034 PortsEn=TopLeft 5'b11010; destination routed north -> packet dropped; route to east is unaffected.
REQ-035 rst pulsed during a body flit with east stalled -> all outputs low immediately; after release, a body flit is discarded, and the next head is routed correctly.

Source files
------------

// File: rtl/noc_mcast_fork.sv
`default_nettype none
// ============================================================================
// Module   : noc_mcast_fork
// Brief    : Zero-latency multicast fork; replicates packets to mesh ports.
// Revision : 1.0
// ============================================================================
module noc_mcast_fork #(
    parameter int         NumDest   = 2,
    parameter int         DataWidth = 64,
    parameter logic [4:0] PortsEn   = 5'b11111
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             position,
    input  logic [DataWidth-1:0]   data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic [5*DataWidth-1:0] data_out,
    output logic [4:0]             data_out_valid,
    input  logic [4:0]             data_out_ready
);

    localparam int c_NUM_PORTS = 5;
    localparam int c_PORT_N    = 0;
    localparam int c_PORT_S    = 1;
    localparam int c_PORT_W    = 2;
    localparam int c_PORT_E    = 3;
    localparam int c_PORT_L    = 4;
    localparam int c_DEST_LSB  = NumDest + 5;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FWD  = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    // X is resolved first, then Y, so routes are deadlock-free in the mesh.
    function automatic logic [4:0] route_port(input logic [5:0] dest, input logic [5:0] pos);
        logic [4:0] onehot;
        onehot = '0;
        if (dest[2:0] > pos[2:0]) begin
            onehot[c_PORT_E] = 1'b1;
        end else if (dest[2:0] < pos[2:0]) begin
            onehot[c_PORT_W] = 1'b1;
        end else if (dest[5:3] < pos[5:3]) begin
            onehot[c_PORT_N] = 1'b1;
        end else if (dest[5:3] > pos[5:3]) begin
            onehot[c_PORT_S] = 1'b1;
        end else begin
            onehot[c_PORT_L] = 1'b1;
        end
        return onehot;
    endfunction

    logic [1:0]                         r_state;
    logic [1:0]                         w_state_nxt;
    logic [4:0]                         r_route_mask;
    logic [4:0]                         r_sent;
    logic [4:0]                         w_sent_nxt;
    logic [NumDest-1:0][4:0]            w_slot_port;
    logic [c_NUM_PORTS-1:0][NumDest-1:0] w_port_val;
    logic [4:0]                         w_route_mask;
    logic [4:0]                         w_active_mask;
    logic [4:0]                         w_offer;
    logic [4:0]                         w_accept;
    logic                               w_is_head;
    logic                               w_is_tail;
    logic                               w_head_idle;

    assign w_is_head   = data_in[DataWidth-1];
    assign w_is_tail   = data_in[DataWidth-2];
    assign w_head_idle = (r_state == c_IDLE) && w_is_head;

    generate
        for (genvar i = 0; i < NumDest; i++) begin : g_slot
            assign w_slot_port[i] = data_in[i]
                ? route_port(data_in[c_DEST_LSB + 6*i +: 6], position)
                : 5'b00000;
        end

        for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_port
            for (genvar i = 0; i < NumDest; i++) begin : g_port_slot
                assign w_port_val[p][i] = w_slot_port[i][p] & PortsEn[p];
            end

            assign w_route_mask[p] = |w_port_val[p];

            // Only a head seen in IDLE is rewritten; everything else passes unchanged.
            assign data_out[p*DataWidth +: DataWidth] = w_head_idle
                ? {data_in[DataWidth-1:NumDest], w_port_val[p]}
                : data_in;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (data_in_ready) begin
            case (r_state)
                c_IDLE: begin
                    if (w_is_head && !w_is_tail) begin
                        w_state_nxt = (w_route_mask == 5'b00000) ? c_DROP : c_FWD;
                    end
                end
                c_FWD, c_DROP: begin
                    if (w_is_tail) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end else if (r_state != c_IDLE && r_state != c_FWD && r_state != c_DROP) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_comb begin
        w_active_mask = 5'b00000;
        case (r_state)
            c_IDLE:  w_active_mask = w_is_head ? w_route_mask : 5'b00000;
            c_FWD:   w_active_mask = r_route_mask;
            default: w_active_mask = 5'b00000;
        endcase

        w_offer        = {5{data_in_valid & ~rst}} & w_active_mask & ~r_sent;
        data_out_valid = w_offer;
        w_accept       = w_offer & data_out_ready;
        // Consumed once every routed port has taken its copy, now or earlier.
        data_in_ready  = data_in_valid & ~rst
                       & ((w_active_mask & ~(r_sent | w_accept)) == 5'b00000);
        w_sent_nxt     = data_in_ready ? 5'b00000 : (r_sent | w_accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sent       <= 5'b00000;
            r_route_mask <= 5'b00000;
        end else begin
            r_sent <= w_sent_nxt;
            if (data_in_ready && w_head_idle) begin
                r_route_mask <= w_route_mask;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_mcast_fork.sv
`default_nettype none
// Scoreboard bench for noc_mcast_fork: directed packets on two instances
// (all ports enabled, and a top-left corner router with north/west disabled).
module tb_noc_mcast_fork;

    typedef struct {
        int          dut;
        int          port;
        logic [63:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [5:0]   pos0, pos1;
    logic [63:0]  din0, din1;
    logic         vin0, vin1;
    logic         rdy0, rdy1;
    logic [319:0] dout0, dout1;
    logic [4:0]   dv0, dv1;
    logic [4:0]   dr0, dr1;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    noc_mcast_fork #(.NumDest(2), .DataWidth(64), .PortsEn(5'b11111)) u_dut0 (
        .clk(clk), .rst(rst), .position(pos0),
        .data_in(din0), .data_in_valid(vin0), .data_in_ready(rdy0),
        .data_out(dout0), .data_out_valid(dv0), .data_out_ready(dr0)
    );

    noc_mcast_fork #(.NumDest(2), .DataWidth(64), .PortsEn(5'b11010)) u_dut1 (
        .clk(clk), .rst(rst), .position(pos1),
        .data_in(din1), .data_in_valid(vin1), .data_in_ready(rdy1),
        .data_out(dout1), .data_out_valid(dv1), .data_out_ready(dr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] xy(input int x, input int y);
        logic [2:0] xx, yy;
        xx = 3'(x);
        yy = 3'(y);
        return {yy, xx};
    endfunction

    function automatic logic [63:0] flit(input logic h, input logic t, input logic [5:0] src,
                                         input logic [4:0] msg, input logic [5:0] d0,
                                         input logic [5:0] d1, input logic [1:0] val,
                                         input logic [36:0] pay);
        return {h, t, pay, src, d1, d0, msg, val};
    endfunction

    function automatic logic [63:0] with_val(input logic [63:0] f, input logic [1:0] v);
        logic [63:0] r;
        r = f;
        r[1:0] = v;
        return r;
    endfunction

    task automatic push(input int d, input int p, input logic [63:0] f);
        exp_t e;
        e.dut = d;
        e.port = p;
        e.data = f;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Presents one flit and waits for it to be consumed; reports the wait and the valids seen.
    task automatic send(input int d, input logic [63:0] f, output int wait_cyc, output logic [4:0] vld);
        if (d == 0) begin din0 = f; vin0 = 1'b1; end
        else        begin din1 = f; vin1 = 1'b1; end
        wait_cyc = 0;
        vld = '0;
        forever begin
            @(negedge clk);
            vld = (d == 0) ? dv0 : dv1;
            if ((d == 0) ? rdy0 : rdy1) break;
            wait_cyc++;
            if (wait_cyc > 40) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=no_ready required=ready dut=%0d", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        vin0 = 1'b0;
        vin1 = 1'b0;
    endtask

    always @(negedge clk) begin
        logic        v, r;
        logic [63:0] dat;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 5; p++) begin
                v   = (d == 0) ? dv0[p] : dv1[p];
                r   = (d == 0) ? dr0[p] : dr1[p];
                dat = (d == 0) ? dout0[p*64 +: 64] : dout1[p*64 +: 64];
                if (v && r) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mon_unexpected actual=dut%0d/port%0d/%h required=none", d, p, dat);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.dut != d || e.port != p || e.data !== dat) begin
                            errors++;
                            $display("FAIL mon_flit actual=dut%0d/port%0d/%h required=dut%0d/port%0d/%h",
                                     d, p, dat, e.dut, e.port, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] h1, b1, t1, s1, h0, h3, x;
        int          w;
        logic [4:0]  v;

        pos0 = xy(3, 3);
        pos1 = xy(3, 3);
        dr0  = 5'b11111;
        dr1  = 5'b11111;

        h1 = flit(1'b1, 1'b0, xy(0, 0), 5'h0A, xy(5, 3), xy(3, 1), 2'b11, 37'h01_2345_6789);
        b1 = flit(1'b0, 1'b0, 6'h15, 5'h13, 6'h2A, 6'h0F, 2'b10, 37'h1F_0F0F_0F0F);
        t1 = flit(1'b0, 1'b1, 6'h3C, 5'h05, 6'h11, 6'h22, 2'b01, 37'h00_DEAD_BEEF);

        // Reset with a valid head on both inputs: nothing may be offered or consumed.
        rst = 1'b1;
        din0 = h1; vin0 = 1'b1;
        din1 = h1; vin1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid0", dv0, 5'b00000);
        chk("reset_ready0", rdy0, 1'b0);
        chk("reset_valid1", dv1, 5'b00000);
        chk("reset_ready1", rdy1, 1'b0);
        vin0 = 1'b0;
        vin1 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-destination head split to north (slot 1) and east (slot 0).
        push(0, 0, with_val(h1, 2'b10));
        push(0, 3, with_val(h1, 2'b01));
        send(0, h1, w, v);
        chk("split_wait", w, 0);
        chk("split_valid", v, 5'b01001);
        push(0, 0, b1); push(0, 3, b1);
        send(0, b1, w, v);
        chk("split_body_valid", v, 5'b01001);
        push(0, 0, t1); push(0, 3, t1);
        send(0, t1, w, v);
        chk("split_tail_wait", w, 0);

        // East stalled for three cycles: north takes the head once and is not re-offered.
        dr0 = 5'b10111;
        push(0, 0, with_val(h1, 2'b10));
        push(0, 3, with_val(h1, 2'b01));
        din0 = h1;
        vin0 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) dr0 = 5'b11111;
            @(negedge clk);
            chk($sformatf("stall_valid_c%0d", c), dv0, (c == 0) ? 5'b01001 : 5'b01000);
            chk($sformatf("stall_ready_c%0d", c), rdy0, (c == 3) ? 1'b1 : 1'b0);
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        vin0 = 1'b0;
        push(0, 0, b1); push(0, 3, b1);
        send(0, b1, w, v);
        chk("stall_body_wait", w, 0);
        push(0, 0, t1); push(0, 3, t1);
        send(0, t1, w, v);

        // Single-flit packet to the local port, then a stray body must be discarded.
        s1 = flit(1'b1, 1'b1, xy(1, 1), 5'h1F, xy(3, 3), xy(3, 3), 2'b11, 37'h0A_5A5A_5A5A);
        push(0, 4, s1);
        send(0, s1, w, v);
        chk("local_valid", v, 5'b10000);
        send(0, b1, w, v);
        chk("idle_body_valid", v, 5'b00000);
        chk("idle_body_wait", w, 0);

        // Head with no valid slot: whole packet dropped at one flit per cycle.
        h0 = flit(1'b1, 1'b0, xy(2, 2), 5'h03, xy(5, 3), xy(3, 1), 2'b00, 37'h00_0000_1234);
        send(0, h0, w, v);
        chk("drop_head_valid", v, 5'b00000);
        chk("drop_head_wait", w, 0);
        send(0, b1, w, v);
        chk("drop_body1_valid", v, 5'b00000);
        send(0, flit(1'b1, 1'b0, 6'h01, 5'h01, 6'h01, 6'h01, 2'b11, 37'h1), w, v);
        chk("drop_body2_valid", v, 5'b00000);
        chk("drop_body2_wait", w, 0);
        send(0, t1, w, v);
        chk("drop_tail_valid", v, 5'b00000);

        // Corner router: north-bound packet is dropped, east-bound routing unaffected.
        x = flit(1'b1, 1'b0, xy(4, 4), 5'h07, xy(3, 1), xy(0, 0), 2'b01, 37'h00_0000_0042);
        send(1, x, w, v);
        chk("corner_north_valid", v, 5'b00000);
        chk("corner_north_wait", w, 0);
        send(1, b1, w, v);
        chk("corner_body_valid", v, 5'b00000);
        send(1, t1, w, v);
        x = flit(1'b1, 1'b1, xy(4, 4), 5'h08, xy(3, 1), xy(5, 3), 2'b11, 37'h00_0000_0099);
        push(1, 3, with_val(x, 2'b10));
        send(1, x, w, v);
        chk("corner_east_valid", v, 5'b01000);

        // Reset mid-packet with east stalled.
        h3 = flit(1'b1, 1'b0, xy(0, 3), 5'h11, xy(6, 3), xy(0, 0), 2'b01, 37'h00_0000_0777);
        push(0, 3, h3);
        send(0, h3, w, v);
        chk("rstpkt_head_valid", v, 5'b01000);
        dr0 = 5'b10111;
        din0 = b1;
        vin0 = 1'b1;
        @(negedge clk);
        chk("rstpkt_body_valid", dv0, 5'b01000);
        chk("rstpkt_body_ready", rdy0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstpkt_async_valid", dv0, 5'b00000);
        chk("rstpkt_async_ready", rdy0, 1'b0);
        @(posedge clk);
        #1;
        vin0 = 1'b0;
        rst = 1'b0;
        dr0 = 5'b11111;
        send(0, b1, w, v);
        chk("post_rst_body_valid", v, 5'b00000);
        chk("post_rst_body_wait", w, 0);
        x = flit(1'b1, 1'b1, xy(2, 6), 5'h12, xy(3, 5), xy(1, 3), 2'b11, 37'h00_0000_0ABC);
        push(0, 1, with_val(x, 2'b01));
        push(0, 2, with_val(x, 2'b10));
        send(0, x, w, v);
        chk("post_rst_head_valid", v, 5'b00110);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
